// File: rtl/mac_ctrl.sv
// mac_ctrl: two-requester round-robin controller that sequences a MAC datapath.
// Define MAC_CTRL_TIMEOUT_EN to build in the RUN watchdog and the ABORT state.
module mac_ctrl #(
    parameter int M              = 4,
    parameter int K              = 4,
    parameter int N              = 4,
    parameter int TIMEOUT_CYCLES = M * N * K + 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic        err,
    output logic        busy,
    output logic        do_mac,
    input  logic        mac_done,
    output logic [15:0] cycle_count
);

`ifdef MAC_CTRL_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE,
        ABORT
    } state_t;

    localparam logic [15:0] TimeoutLim = 16'(TIMEOUT_CYCLES);
`else
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    state_t      state_q, state_d;
    logic        win_q, win_d;
    logic        ptr_q, ptr_d;
    logic [15:0] run_cnt_q, run_cnt_d;
    logic [15:0] cyc_cnt_q, cyc_cnt_d;
    logic        pick;
    logic        mac_valid;
    logic [1:0]  win_onehot;

    // On a tie the requester not served last wins.
    assign pick = (req == 2'b11) ? ~ptr_q : req[1];

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        ptr_d     = ptr_q;
        run_cnt_d = run_cnt_q;
        cyc_cnt_d = cyc_cnt_q;
        mac_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    win_d     = pick;
                    run_cnt_d = 16'd1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // First RUN cycle may see a stale completion.
                mac_valid = mac_done && (run_cnt_q != 16'd1);
                if (run_cnt_q != 16'hFFFF) begin
                    run_cnt_d = run_cnt_q + 16'd1;
                end
                if (mac_valid) begin
                    cyc_cnt_d = run_cnt_q;
                    state_d   = DONE;
                end
`ifdef MAC_CTRL_TIMEOUT_EN
                else if (run_cnt_q == TimeoutLim) begin
                    cyc_cnt_d = TimeoutLim;
                    state_d   = ABORT;
                end
`endif
            end
            DONE: begin
                ptr_d   = win_q;
                state_d = IDLE;
            end
`ifdef MAC_CTRL_TIMEOUT_EN
            ABORT: begin
                ptr_d   = win_q;
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            win_q     <= 1'b0;
            ptr_q     <= 1'b1;
            run_cnt_q <= 16'd0;
            cyc_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            ptr_q     <= ptr_d;
            run_cnt_q <= run_cnt_d;
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    assign win_onehot  = win_q ? 2'b10 : 2'b01;
    assign busy        = (state_q != IDLE);
    assign do_mac      = (state_q == RUN);
    assign gnt         = do_mac ? win_onehot : 2'b00;
    assign cycle_count = cyc_cnt_q;

`ifdef MAC_CTRL_TIMEOUT_EN
    assign err  = (state_q == ABORT);
    assign done = ((state_q == DONE) || (state_q == ABORT)) ? win_onehot : 2'b00;
`else
    assign err  = 1'b0;
    assign done = (state_q == DONE) ? win_onehot : 2'b00;
`endif

endmodule
